// File: rtl/cda_reconfig_pkg.sv
// Shared field layout, mode strings, FSM states and mode decode for the
// PLL scale-counter reconfiguration loader.
package cda_reconfig_pkg;

    localparam int CNTR_CFG_W = 18;
    localparam int CNT_W      = 8;
    localparam int MODE_W     = 48;

    localparam int LOW_LSB    = 0;
    localparam int ODD_BIT    = 8;
    localparam int HIGH_LSB   = 9;
    localparam int BYPASS_BIT = 17;

    localparam logic [MODE_W-1:0] MODE_OFF    = "   off";
    localparam logic [MODE_W-1:0] MODE_BYPASS = "bypass";
    localparam logic [MODE_W-1:0] MODE_ODD    = "   odd";
    localparam logic [MODE_W-1:0] MODE_EVEN   = "  even";

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE,
        HOLD
    } state_t;

    // Bypass dominates, then a zero high count switches the counter off.
    function automatic logic [MODE_W-1:0] decode_mode(
        input logic             bypass,
        input logic [CNT_W-1:0] high,
        input logic             odd
    );
        if (bypass)
            return MODE_BYPASS;
        else if (high == '0)
            return MODE_OFF;
        else if (odd)
            return MODE_ODD;
        else
            return MODE_EVEN;
    endfunction

endpackage

// File: rtl/cda_cntr_cfg_slot.sv
// One scale counter's active high/low/odd/bypass settings, loaded from its
// 18-bit scan slice on commit, plus the combinational mode string.
module cda_cntr_cfg_slot
    import cda_reconfig_pkg::*;
#(
    parameter int INIT_HIGH = 1,
    parameter int INIT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [CNTR_CFG_W-1:0] cfg,
    output logic [CNT_W-1:0]      high,
    output logic [CNT_W-1:0]      low,
    output logic [MODE_W-1:0]     mode
);

    logic odd;
    logic bypass;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            high   <= CNT_W'(INIT_HIGH);
            low    <= CNT_W'(INIT_LOW);
            odd    <= 1'b0;
            bypass <= 1'b0;
        end else if (load) begin
            high   <= cfg[HIGH_LSB +: CNT_W];
            low    <= cfg[LOW_LSB +: CNT_W];
            odd    <= cfg[ODD_BIT];
            bypass <= cfg[BYPASS_BIT];
        end
    end

    assign mode = decode_mode(bypass, high, odd);

endmodule

// File: rtl/cda_scale_cntr_reconfig.sv
// Serial scan-chain loader for the PLL scale counters: shifts, length-checks and
// commits settings, then holds cntr_reset. Optional CDA_RECONFIG_READBACK_EN adds scandataout.
module cda_scale_cntr_reconfig
    import cda_reconfig_pkg::*;
#(
    parameter int NUM_CNTR     = 5,
    parameter int RESET_CYCLES = 4,
    parameter int INIT_HIGH    = 1,
    parameter int INIT_LOW     = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         scandata,
    input  logic                         scanclkena,
    input  logic                         configupdate,
    output logic                         busy,
    output logic                         scandone,
    output logic                         cfg_err,
    output logic                         cntr_reset,
    output logic [NUM_CNTR*CNT_W-1:0]    cntr_high,
    output logic [NUM_CNTR*CNT_W-1:0]    cntr_low,
    output logic [NUM_CNTR*MODE_W-1:0]   cntr_mode
`ifdef CDA_RECONFIG_READBACK_EN
    ,
    output logic                         scandataout
`endif
);

    localparam int          L         = NUM_CNTR * CNTR_CFG_W;
    localparam logic [15:0] SCAN_LEN  = 16'(L);
    localparam logic [15:0] CNT_SAT   = 16'(L + 1);
    localparam logic [7:0]  HOLD_LAST = 8'(RESET_CYCLES - 1);

    state_t       state;
    logic [L-1:0] sr;
    logic [15:0]  shift_cnt;
    logic [7:0]   hold_cnt;
    logic         load;

    assign load = (state == UPDATE);

    // Configupdate takes priority over a shift in the same cycle, so a late bit is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            sr         <= '0;
            shift_cnt  <= '0;
            hold_cnt   <= '0;
            busy       <= 1'b0;
            scandone   <= 1'b0;
            cfg_err    <= 1'b0;
            cntr_reset <= 1'b1;
        end else begin
            scandone <= 1'b0;
            case (state)
                IDLE: begin
                    cntr_reset <= 1'b0;
                    if (scanclkena) begin
                        sr        <= {sr[L-2:0], scandata};
                        shift_cnt <= 16'd1;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (configupdate) begin
                        if (shift_cnt == SCAN_LEN) begin
                            cntr_reset <= 1'b1;
                            state      <= UPDATE;
                        end else begin
                            cfg_err   <= 1'b1;
                            busy      <= 1'b0;
                            shift_cnt <= '0;
                            state     <= IDLE;
                        end
                    end else if (scanclkena) begin
                        sr <= {sr[L-2:0], scandata};
                        if (shift_cnt != CNT_SAT)
                            shift_cnt <= shift_cnt + 16'd1;
                    end
                end
                UPDATE: begin
                    // The committed image uses sr's own field layout, so sr already holds it for readback.
                    cfg_err   <= 1'b0;
                    shift_cnt <= '0;
                    hold_cnt  <= '0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        cntr_reset <= 1'b0;
                        scandone   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CDA_RECONFIG_READBACK_EN
    assign scandataout = sr[L-1];
`endif

    for (genvar k = 0; k < NUM_CNTR; k++) begin : g_slot
        cda_cntr_cfg_slot #(
            .INIT_HIGH (INIT_HIGH),
            .INIT_LOW  (INIT_LOW)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load),
            .cfg     (sr[k*CNTR_CFG_W +: CNTR_CFG_W]),
            .high    (cntr_high[k*CNT_W +: CNT_W]),
            .low     (cntr_low[k*CNT_W +: CNT_W]),
            .mode    (cntr_mode[k*MODE_W +: MODE_W])
        );
    end

endmodule

// File: tb/tb_cda_scale_cntr_reconfig.sv
// Scoreboard bench for cda_scale_cntr_reconfig: directed scan loads push expected
// commit/error events; a monitor pops and checks them on scandone or busy falling.
module tb_cda_scale_cntr_reconfig;

    localparam int L = 90;
    localparam logic [39:0]  DEF_HL   = 40'h01_01_01_01_01;
    localparam logic [239:0] DEF_MODE = {"  even", "  even", "  even", "  even", "  even"};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         scandata = 1'b0;
    logic         scanclkena = 1'b0;
    logic         configupdate = 1'b0;
    logic         busy;
    logic         scandone;
    logic         cfg_err;
    logic         cntr_reset;
    logic [39:0]  cntr_high;
    logic [39:0]  cntr_low;
    logic [239:0] cntr_mode;
`ifdef CDA_RECONFIG_READBACK_EN
    logic         scandataout;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit           is_commit;
        logic [39:0]  high;
        logic [39:0]  low;
        logic [239:0] mode;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   busy_q = 1'b0;

    cda_scale_cntr_reconfig dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scandata     (scandata),
        .scanclkena   (scanclkena),
        .configupdate (configupdate),
        .busy         (busy),
        .scandone     (scandone),
        .cfg_err      (cfg_err),
        .cntr_reset   (cntr_reset),
        .cntr_high    (cntr_high),
        .cntr_low     (cntr_low),
        .cntr_mode    (cntr_mode)
`ifdef CDA_RECONFIG_READBACK_EN
        ,
        .scandataout  (scandataout)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [239:0] actual, input logic [239:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [17:0] slice(input bit bp, input logic [7:0] hi, input bit odd, input logic [7:0] lo);
        return {bp, hi, odd, lo};
    endfunction

    // Shift nbits of img MSB-first, then pulse configupdate (optionally with a stray shift bit).
    task automatic applyStimulus(input logic [L-1:0] img, input int nbits, input bit overlap,
                                 input bit push, input bit is_commit,
                                 input logic [39:0] e_high, input logic [39:0] e_low,
                                 input logic [239:0] e_mode);
        exp_t e;
        for (int i = nbits - 1; i >= 0; i--) begin
            scanclkena = 1'b1;
            scandata   = img[i];
            @(posedge clk); #1;
        end
        scanclkena = 1'b0;
        scandata   = 1'b0;
        if (push) begin
            e.is_commit = is_commit;
            e.high      = e_high;
            e.low       = e_low;
            e.mode      = e_mode;
            exp_q.push_back(e);
        end
        configupdate = 1'b1;
        if (overlap) begin
            scanclkena = 1'b1;
            scandata   = 1'b1;
        end
        @(posedge clk); #1;
        configupdate = 1'b0;
        scanclkena   = 1'b0;
        scandata     = 1'b0;
    endtask

    task automatic watch_pulses(input bit expect_commit, input logic [39:0] old_high, input logic [39:0] new_high);
        int rst_width = 0;
        int sd_idx = 99;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cntr_reset) rst_width++;
            if (scandone && sd_idx == 99) sd_idx = k;
            if (k == 0) checkOutput("high_before_update", cntr_high, old_high);
            if (k == 1) checkOutput("high_after_update", cntr_high, new_high);
        end
        checkOutput("cntr_reset_width", rst_width, expect_commit ? 5 : 0);
        checkOutput("scandone_cycle", sd_idx, expect_commit ? 5 : 99);
        checkOutput("busy_after", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    // Monitor: a commit shows up as scandone, a rejected scan as busy falling without scandone.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy_q = 1'b0;
            end else begin
                if (scandone || (busy_q && !busy)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_event scandone=%0b cfg_err=%0b expected no event",
                                 scandone, cfg_err);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("event_kind", scandone, mon_e.is_commit);
                        checkOutput("event_cfg_err", cfg_err, !mon_e.is_commit);
                        checkOutput("event_high", cntr_high, mon_e.high);
                        checkOutput("event_low", cntr_low, mon_e.low);
                        checkOutput("event_mode", cntr_mode, mon_e.mode);
                        checkOutput("event_cntr_reset", cntr_reset, 1'b0);
                    end
                end
                busy_q = busy;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [L-1:0]  img1, img2, img3;
    logic [39:0]   high1, low1, high2, low2, high3, low3;
    logic [239:0]  mode1, mode2, mode3;
    int            sd_cnt;
`ifdef CDA_RECONFIG_READBACK_EN
    logic [L-1:0]  rb;
`endif

    initial begin
        img1  = {slice(0, 8'hFF, 1, 8'h80), slice(1, 8'h09, 0, 8'h09), slice(0, 8'h03, 1, 8'h02),
                 slice(0, 8'h00, 0, 8'h07), slice(0, 8'h05, 0, 8'h04)};
        high1 = {8'hFF, 8'h09, 8'h03, 8'h00, 8'h05};
        low1  = {8'h80, 8'h09, 8'h02, 8'h07, 8'h04};
        mode1 = {"   odd", "bypass", "   odd", "   off", "  even"};

        img2  = {slice(0, 8'h02, 0, 8'h03), slice(0, 8'h80, 1, 8'hFF), slice(0, 8'h01, 0, 8'h00),
                 slice(1, 8'h00, 0, 8'h22), slice(0, 8'h00, 1, 8'h11)};
        high2 = {8'h02, 8'h80, 8'h01, 8'h00, 8'h00};
        low2  = {8'h03, 8'hFF, 8'h00, 8'h22, 8'h11};
        mode2 = {"  even", "   odd", "  even", "bypass", "   off"};

        img3  = {slice(0, 8'h0A, 1, 8'hF0), slice(0, 8'h09, 0, 8'h0F), slice(0, 8'h08, 1, 8'hAA),
                 slice(0, 8'h07, 0, 8'h55), slice(0, 8'h06, 0, 8'h55)};
        high3 = {8'h0A, 8'h09, 8'h08, 8'h07, 8'h06};
        low3  = {8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h55};
        mode3 = {"   odd", "  even", "   odd", "  even", "  even"};

        // Reset state and cntr_reset release timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cntr_reset", cntr_reset, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_scandone", scandone, 1'b0);
        checkOutput("rst_cfg_err", cfg_err, 1'b0);
        checkOutput("rst_high", cntr_high, DEF_HL);
        checkOutput("rst_low", cntr_low, DEF_HL);
        checkOutput("rst_mode", cntr_mode, DEF_MODE);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("cntr_reset_before_release_edge", cntr_reset, 1'b1);
        @(negedge clk);
        checkOutput("cntr_reset_released", cntr_reset, 1'b0);
        @(posedge clk); #1;

        // A lone configupdate in IDLE does nothing.
        configupdate = 1'b1;
        @(posedge clk); #1;
        configupdate = 1'b0;
        @(negedge clk);
        checkOutput("idle_update_busy", busy, 1'b0);
        checkOutput("idle_update_cntr_reset", cntr_reset, 1'b0);
        checkOutput("idle_update_high", cntr_high, DEF_HL);
        @(posedge clk); #1;

        $display("[TB] full load, counter 2 = 3/2/odd");
        applyStimulus(img1, L, 0, 1, 1, high1, low1, mode1);
        watch_pulses(1, DEF_HL, high1);

        $display("[TB] short load of 89 bits");
        applyStimulus(img2, L - 1, 0, 1, 0, high1, low1, mode1);
        watch_pulses(0, high1, high1);
        checkOutput("cfg_err_sticky", cfg_err, 1'b1);

        $display("[TB] full load clears cfg_err, off/bypass priority");
        applyStimulus(img2, L, 0, 1, 1, high2, low2, mode2);
        watch_pulses(1, high1, high2);

        $display("[TB] shift and configupdate together on bit L+1");
        applyStimulus(img3, L, 1, 1, 1, high3, low3, mode3);
        watch_pulses(1, high2, high3);

        $display("[TB] reset during HOLD");
        applyStimulus(img1, L, 0, 0, 1, high1, low1, mode1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_new_high", cntr_high, high1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_high", cntr_high, DEF_HL);
        checkOutput("abort_low", cntr_low, DEF_HL);
        checkOutput("abort_mode", cntr_mode, DEF_MODE);
        checkOutput("abort_cntr_reset", cntr_reset, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        sd_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (scandone) sd_cnt++;
        end
        checkOutput("abort_no_scandone", sd_cnt, 0);
        checkOutput("abort_cntr_reset_released", cntr_reset, 1'b0);
        @(posedge clk); #1;

`ifdef CDA_RECONFIG_READBACK_EN
        $display("[TB] readback of committed stream");
        applyStimulus(img1, L, 0, 1, 1, high1, low1, mode1);
        watch_pulses(1, DEF_HL, high1);
        rb = '0;
        for (int i = 0; i < L; i++) begin
            rb[L-1-i]  = scandataout;
            scanclkena = 1'b1;
            scandata   = 1'b0;
            @(posedge clk); #1;
        end
        scanclkena = 1'b0;
        checkOutput("readback_stream", rb, img1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
